alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised iterative multiply/divide unit for the RV32M/RV64M integer extension, the multi-cycle companion to the single-cycle integer ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake, computes the product or quotient/remainder by shift-add or restoring division over XLEN iterations, and returns the XLEN-bit result over a second valid/ready handshake. Divide-by-zero and signed overflow are resolved in one cycle with the architected RISC-V results.

## Interface
- XLEN, 32: operand and result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abort any operation in progress; no result is produced.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  XLEN  result; held stable while out_valid && !out_ready.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, latch op. Store |a| and |b| per signedness: MUL/MULHU/DIVU/REMU unsigned; MULH/DIV/REM both signed; MULHSU a signed, b unsigned. Record result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Special cases, div/rem only, detected at accept, go IDLE->DONE directly:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - DIV with a==most-negative and b==-1 -> a; REM in the same case -> 0.
- Otherwise IDLE->BUSY, counter=0.
- BUSY, multiply: 2*XLEN-bit accumulator, shift-add, one multiplier bit per cycle.
- BUSY, divide: restoring division, one quotient bit per cycle, remainder XLEN+1 bits.
- Leave BUSY after exactly XLEN iterations (counter==XLEN-1 -> DONE). On entry to DONE, the final conditional two's-complement negation is applied and out is registered.
- Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of the signed-corrected 2*XLEN product; DIV/DIVU quotient; REM/REMU remainder.
- DONE: out_valid=1 until out_ready; then DONE->IDLE. No new op is accepted in the same cycle (in_ready=0 in DONE).
- flush: from any state, next state IDLE, out_valid=0 next cycle, and any pending result is dropped. flush has priority over in_valid and out_ready in the same cycle. A flush in IDLE with in_valid high does not accept the operation.
- Arithmetic is modulo 2^XLEN; signed interpretation is two's complement only.

## Timing
- Reset (rst=1 at a clock edge): state IDLE, in_ready=1, out_valid=0, out=0, counter=0, internal accumulators 0. Reset mid-operation behaves like flush and also clears out.
- Normal op: accept at edge N; out_valid=1 from edge N+XLEN+1 (33 cycles for XLEN=32).
- Special-case div: out_valid=1 from edge N+1.
- Back-to-back throughput: at most one op per XLEN+2 cycles (normal) or 2 cycles (special case) with out_ready held high.
- in_ready is a function of registered state only; no combinational path from inputs.
- out and out_valid are registered. out is not updated while DONE stalls.

## Test plan
- Reset then idle: rst for 2 cycles -> in_ready=1, out_valid=0, out=0; no activity with in_valid=0.
- MUL/MULH/MULHSU/MULHU, a=0xFFFFFFFF, b=0x00000002 (XLEN=32) -> 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001; out_valid exactly 33 cycles after accept.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU same operands -> 0x7FFFFFFC; REMU -> 0x00000001.
- Special cases: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each has out_valid one cycle after accept.
- Backpressure and flush: hold out_ready=0 for 10 cycles in DONE -> out stable and in_ready=0. Assert flush at BUSY cycle 5 -> IDLE next cycle, out_valid never asserts. A new op then accepted completes correctly.
- XLEN=64 build: MULHU 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE after 65 cycles. Random signed/unsigned ops are checked against a reference model, including a simultaneous flush+in_valid in IDLE (not accepted).

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative RV32M/RV64M multiply/divide unit.
//
// Accepts one operation at a time, runs XLEN shift-add (multiply) or
// restoring-division (divide) iterations on operand magnitudes, then applies
// the result sign and registers the selected XLEN-bit result. Division by
// zero and signed overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      abort any operation in progress, drop any pending result
//   in_valid   operation request
//   in_ready   unit can accept (IDLE only)
//   op         RISC-V funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       rs1 / rs2 operands
//   out_valid  result available
//   out_ready  consumer takes result
//   out        result, stable while out_valid && !out_ready
module alu_muldiv #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]   ONE_X  = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(XLEN - 1);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opa_q, opa_d;    // |a| (multiplicand)
  logic [XLEN-1:0]     opb_q, opb_d;    // |b| (divisor)
  logic                neg_q, neg_d;    // negate final result
  // Multiply: {partial product high, multiplier/low product}.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // Partial remainder; it is always below the divisor, so XLEN bits hold it.
  // The XLEN+1-bit working value is div_shift below.
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     out_q, out_d;

  // ---------------- accept-time decode ----------------
  logic            a_signed, b_signed, sa, sb;
  logic            in_div, b_zero, div_ovf, neg_in;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    abs_a    = sa ? (~a + ONE_X) : a;
    abs_b    = sb ? (~b + ONE_X) : b;
    in_div   = op[2];
    b_zero   = (b == '0);
    // Only the signed DIV/REM (op[0]==0) can overflow.
    div_ovf  = op[2] & ~op[0] & (a == MIN_X) & (b == '1);
    // Remainder takes the dividend sign; product/quotient take sa^sb.
    neg_in   = (in_div & op[1]) ? sa : (sa ^ sb);
    if (b_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : a;
    end
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   quo_next, rem_next;

  always_comb begin
    // Shift-add, LSB-first: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Restoring division: bring down the next dividend bit, subtract if it fits.
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_next  = {acc_q[XLEN-2:0], div_ge};
  end

  // ---------------- final sign correction and select ----------------
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, res_fin;

  always_comb begin
    prod_fin = neg_q ? (~mul_next + ONE_2X) : mul_next;
    quo_fin  = neg_q ? (~quo_next + ONE_X) : quo_next;
    rem_fin  = neg_q ? (~rem_next + ONE_X) : rem_next;
    case (op_q)
      3'b000:                 res_fin = prod_fin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_fin[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_fin = quo_fin;
      default:                res_fin = rem_fin;
    endcase
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    if (flush) begin
      // Flush wins over in_valid and out_ready; nothing is latched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            opa_d = abs_a;
            opb_d = abs_b;
            neg_d = neg_in;
            cnt_d = '0;
            if (in_div && (b_zero || div_ovf)) begin
              state_d = S_DONE;
              out_d   = special_res;
            end else begin
              state_d = S_BUSY;
              acc_d   = {{XLEN{1'b0}}, (in_div ? abs_a : abs_b)};
              rem_d   = '0;
            end
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
            rem_d = rem_next;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            out_d   = res_fin;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv: directed corner cases plus randomized operations
// checked against an arithmetic reference model, for XLEN=32 and XLEN=64.
module tb_alu_muldiv;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [2:0]  op64;
  logic [63:0] a64;
  logic [63:0] b64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out64;

  int n_cmp = 0;
  int n_err = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .op(op64), .a(a64), .b(b64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out(out64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model32(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [31:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // 64-bit model for the unsigned ops exercised on the wide build.
  function automatic logic [63:0] model64(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y);
    logic [127:0] p;
    logic [63:0]  r;
    p = {64'b0, x} * {64'b0, y};
    case (o)
      3'd0:    r = p[63:0];
      3'd3:    r = p[127:64];
      3'd5:    r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 15));
      5:       v = 32'h0 - 32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One full transaction on the 32-bit unit: accept, latency, result, stall, release.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int stall);
    logic [31:0] exp_v;
    logic [31:0] held;
    int          lat;
    int          exp_lat;
    exp_v   = model32(o, x, y);
    exp_lat = (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
              ? 1 : 33;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", 64'(out), 64'(exp_v));
    chk("in_ready_done", 64'(in_ready), 64'd0);
    held = out;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_out", 64'(out), 64'(held));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released", 64'(out_valid), 64'd0);
    $display("xlen=32 op=%0d a=%h b=%h out=%h exp=%h lat=%0d", o, x, y, held, exp_v, lat);
  endtask

  task automatic do_op64(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] exp_v;
    logic [63:0] got;
    int          lat;
    int          exp_lat;
    exp_v   = model64(o, x, y);
    exp_lat = (o[2] && y == 0) ? 1 : 65;
    @(negedge clk);
    chk("in_ready64_idle", 64'(in_ready64), 64'd1);
    in_valid64 = 1'b1;
    op64 = o; a64 = x; b64 = y;
    @(negedge clk);
    in_valid64 = 1'b0;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = 1;
    while (!out_valid64 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency64", 64'(lat), 64'(exp_lat));
    chk("result64", out64, exp_v);
    got = out64;
    out_ready64 = 1'b1;
    @(negedge clk);
    out_ready64 = 1'b0;
    chk("released64", 64'(out_valid64), 64'd0);
    $display("xlen=64 op=%0d a=%h b=%h out=%h exp=%h lat=%0d", o, x, y, got, exp_v, lat);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    flush64 = 1'b0; in_valid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; out_ready64 = 1'b0;

    // Reset, then idle with no requests.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_in_ready64", 64'(in_ready64), 64'd1);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    chk("idle_quiet", 64'(seen), 64'd0);

    // Multiply family.
    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 10);
    do_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    // Divide family.
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    do_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    do_op(3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    // Special cases.
    do_op(3'd4, 32'h0000_0005, 32'h0000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    do_op(3'd7, 32'h0000_0005, 32'h0000_0000, 0);

    // Reset mid-operation clears the held result (out currently 5).
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);

    // Flush at BUSY cycle 5.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op(3'd4, 32'h0000_0064, 32'hFFFF_FFF9, 0);

    // Flush together with in_valid in IDLE: not accepted.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h5; b = 32'h0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_ready", 64'(in_ready), 64'd1);
    chk("flush_accept_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("flush_accept_valid2", 64'(out_valid), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), pick32(), pick32(), $urandom_range(0, 2));
    end

    // Wide build.
    do_op64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op64(3'd5, 64'h0000_0000_0000_0005, 64'h0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] o;
      case ($urandom_range(0, 3))
        0:       o = 3'd0;
        1:       o = 3'd3;
        2:       o = 3'd5;
        default: o = 3'd7;
      endcase
      do_op64(o, {$urandom, $urandom}, {32'($urandom_range(0, 3)), $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
